// File: rtl/differ_pkg.sv
// rtl/differ_pkg.sv - shared constants and saturation bound helpers for differ
package differ_pkg;

  localparam int DEFAULT_WIDTH = 12;

  // Largest value representable in a w-bit two's-complement word (w in 2..32).
  function automatic logic signed [32:0] sat_max(input int w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  // Smallest value representable in a w-bit two's-complement word (w in 2..32).
  function automatic logic signed [32:0] sat_min(input int w);
    return -(33'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/differ_sat_sub.sv
// rtl/differ_sat_sub.sv - combinational signed a-b with optional clamp to WIDTH range
module differ_sat_sub
  import differ_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] y_o
);

  if (SATURATE) begin : g_sat
    localparam logic signed [32:0]    MAX_L = sat_max(WIDTH);
    localparam logic signed [32:0]    MIN_L = sat_min(WIDTH);
    localparam logic signed [WIDTH:0] MAX_W = MAX_L[WIDTH:0];
    localparam logic signed [WIDTH:0] MIN_W = MIN_L[WIDTH:0];

    logic signed [WIDTH:0] diff;

    // One extra bit keeps the true difference exact so overflow can be detected.
    assign diff = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

    // Clamp the exact difference into the representable range.
    always_comb begin
      y_o = diff[WIDTH-1:0];
      if (diff > MAX_W) begin
        y_o = MAX_W[WIDTH-1:0];
      end else if (diff < MIN_W) begin
        y_o = MIN_W[WIDTH-1:0];
      end
    end
  end else begin : g_wrap
    // The low WIDTH bits of the widened difference equal a plain WIDTH-bit subtract.
    assign y_o = a_i - b_i;
  end

endmodule

// File: rtl/differ.sv
// rtl/differ.sv - first difference of consecutive accepted samples, one-cycle latency
module differ
  import differ_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ivalid,
  input  logic signed [WIDTH-1:0] idata,
  output logic                    ovalid,
  output logic signed [WIDTH-1:0] odata
);

  logic signed [WIDTH-1:0] prev_q, prev_d;
  logic                    primed_q, primed_d;
  logic signed [WIDTH-1:0] odata_q, odata_d;
  logic                    ovalid_q, ovalid_d;
  logic signed [WIDTH-1:0] diff;

  differ_sat_sub #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_sat_sub (
    .a_i(idata),
    .b_i(prev_q),
    .y_o(diff)
  );

  // Next state: idle cycles hold everything; the first sample after reset reports 0.
  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    if (ivalid) begin
      ovalid_d = 1'b1;
      prev_d   = idata;
      primed_d = 1'b1;
      odata_d  = primed_q ? diff : '0;
    end
  end

  // State registers; reset wins over a sample presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;

endmodule

// File: tb/tb_differ.sv
// tb/tb_differ.sv - directed self-checking bench for differ (saturating and wrapping)
module tb_differ;

  logic               clock;
  logic               reset;
  logic               ivalid;
  logic signed [11:0] idata;
  logic               ovalid_s, ovalid_w;
  logic signed [11:0] odata_s, odata_w;

  int total = 0;
  int bad   = 0;

  differ #(.WIDTH(12), .SATURATE(1'b1)) u_sat (
    .clock (clock),
    .reset (reset),
    .ivalid(ivalid),
    .idata (idata),
    .ovalid(ovalid_s),
    .odata (odata_s)
  );

  differ #(.WIDTH(12), .SATURATE(1'b0)) u_wrap (
    .clock (clock),
    .reset (reset),
    .ivalid(ivalid),
    .idata (idata),
    .ovalid(ovalid_w),
    .odata (odata_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset(input logic iv, input logic signed [11:0] d);
    @(negedge clock);
    reset = 1'b1; ivalid = iv; idata = d;
    @(posedge clock); #1;
    chk("rst_ovalid_s", {11'b0, ovalid_s}, 12'd0);
    chk("rst_ovalid_w", {11'b0, ovalid_w}, 12'd0);
    chk("rst_odata_s", odata_s, 12'd0);
    @(negedge clock);
    reset = 1'b0; ivalid = 1'b0; idata = '0;
    @(posedge clock); #1;
    chk("post_rst_ovalid", {11'b0, ovalid_s}, 12'd0);
  endtask

  task automatic send(input string tag, input logic signed [11:0] v,
                      input logic signed [11:0] es, input logic signed [11:0] ew);
    @(negedge clock);
    ivalid = 1'b1; idata = v;
    @(posedge clock); #1;
    chk({tag, "_ovalid_s"}, {11'b0, ovalid_s}, 12'd1);
    chk({tag, "_ovalid_w"}, {11'b0, ovalid_w}, 12'd1);
    chk({tag, "_odata_s"}, odata_s, es);
    chk({tag, "_odata_w"}, odata_w, ew);
    @(negedge clock);
    ivalid = 1'b0; idata = 12'sd99;
    @(posedge clock); #1;
    chk({tag, "_gap_ovalid"}, {11'b0, ovalid_s}, 12'd0);
    chk({tag, "_gap_odata"}, odata_s, es);
  endtask

  initial begin
    reset = 1'b0; ivalid = 1'b0; idata = '0;

    // Basic sequence
    do_reset(1'b0, 12'sd0);
    send("s5",  12'sd5,  12'sd0,  12'sd0);
    send("s10", 12'sd10, 12'sd5,  12'sd5);
    send("s7",  12'sd7,  -12'sd3, -12'sd3);
    send("s0",  12'sd0,  -12'sd7, -12'sd7);
    send("sm3", -12'sd3, -12'sd3, -12'sd3);

    // Idle hold: 10 idle cycles, then difference uses pre-idle prev (-3)
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("idle_ovalid", {11'b0, ovalid_s}, 12'd0);
      chk("idle_odata", odata_s, -12'sd3);
    end
    send("after_idle", 12'sd4, 12'sd7, 12'sd7);

    // Saturation on positive overflow; wrap gives -1
    do_reset(1'b0, 12'sd0);
    send("sat0",    12'sd0,   12'sd0,    12'sd0);
    send("satmin",  -12'sd2048, -12'sd2048, -12'sd2048);
    send("satmax",  12'sd2047, 12'sd2047, -12'sd1);
    // Negative overflow: 2047 -> -2048 is -4095
    send("satneg",  -12'sd2048, -12'sd2048, 12'sd1);

    // Wrap sequence straight from reset
    do_reset(1'b0, 12'sd0);
    send("wrap0", -12'sd2048, 12'sd0, 12'sd0);
    send("wrap1", 12'sd2047, 12'sd2047, -12'sd1);

    // Mid-stream reset with a sample presented during reset
    do_reset(1'b0, 12'sd0);
    send("m100", 12'sd100, 12'sd0,   12'sd0);
    send("m200", 12'sd200, 12'sd100, 12'sd100);
    do_reset(1'b1, 12'sd77);
    send("m50",  12'sd50,  12'sd0,   12'sd0);

    // Full throughput: samples 1..8 back to back
    do_reset(1'b0, 12'sd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      ivalid = 1'b1; idata = 12'(i);
      @(posedge clock); #1;
      chk("tp_ovalid", {11'b0, ovalid_s}, 12'd1);
      chk("tp_odata", odata_s, (i == 1) ? 12'sd0 : 12'sd1);
    end
    @(negedge clock);
    ivalid = 1'b0;
    @(posedge clock); #1;
    chk("tp_end_ovalid", {11'b0, ovalid_s}, 12'd0);
    chk("tp_end_odata", odata_s, 12'sd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/differ.md
DIFFER -- requirements
Module: differ

Interface
REQ-001 Parameter WIDTH, default 12: sample width in bits, two's-complement signed, legal range 2..32.
REQ-002 Parameter SATURATE, default 1: 1 clamps the difference to the WIDTH range; 0 wraps modulo 2^WIDTH.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 Port ivalid, input, 1: idata carries a new sample this cycle.
REQ-006 Port idata, input, WIDTH, signed: input sample.
REQ-007 Port ovalid, output, 1: odata was updated on the preceding edge; one-cycle pulse per accepted sample.
REQ-008 Port odata, output, WIDTH, signed: first difference of consecutive accepted samples.

Function
REQ-009 Accepted sample: any cycle with ivalid=1 and reset=0. Cycles with ivalid=0 leave all state unchanged and do not count as samples.
REQ-010 Internal state: prev (WIDTH, signed) holds the last accepted sample; primed (1 bit) is set once a sample has been accepted since reset.
REQ-011 On an accepted sample with primed=0: odata <= 0, prev <= idata, primed <= 1, ovalid <= 1.
REQ-012 On an accepted sample with primed=1: odata <= idata - prev, prev <= idata, ovalid <= 1.
REQ-013 Subtraction is computed at WIDTH+1 bits, sign-extended.
REQ-014 With SATURATE=1, results above 2^(WIDTH-1)-1 clamp to that value, and results below -2^(WIDTH-1) clamp to -2^(WIDTH-1).
REQ-015 With SATURATE=0, odata is the low WIDTH bits of the result.
REQ-016 Latency is exactly one clock from the accepting edge to odata/ovalid.
REQ-017 ovalid is high for exactly one cycle per accepted sample. Back-to-back accepted samples give back-to-back ovalid pulses at full throughput.
REQ-018 odata holds its last value between ovalid pulses.
REQ-019 There is no backpressure: the block accepts a sample every cycle.

Reset
REQ-020 While reset=1 on a rising edge: odata <= 0, ovalid <= 0, prev <= 0, primed <= 0.
REQ-021 Reset has priority over ivalid: a sample presented in a reset cycle is discarded.
REQ-022 Reset applied mid-stream clears primed, so the first sample after reset outputs 0.
REQ-023 Outputs are undefined before the first reset.

Structure
REQ-024 A shared package holds the default WIDTH constant and a function for the saturation bounds (max/min for a given WIDTH).
REQ-025 One sub-module, differ_sat_sub, is natural: combinational WIDTH-bit signed subtractor with an optional saturation stage, parameterized by WIDTH and SATURATE.
REQ-026 The top level holds the prev, primed, odata and ovalid registers and instantiates differ_sat_sub.

Verification
REQ-027 Sequence: reset pulse, then single-cycle ivalid samples 5, 10, 7, 0, -3 separated by idle cycles. Required odata after each sample: 0, 5, -3, -7, -3. Each with a one-cycle ovalid pulse one clock after acceptance.
REQ-028 Idle hold: after a sample, run 10 idle cycles. odata stays constant, ovalid stays 0, and the next sample's difference uses the pre-idle prev.
REQ-029 Saturation (WIDTH=12, SATURATE=1): samples 0, then -2048, then 2047 give odata 0, -2048, 2047. The last case clamps from 4095.
REQ-030 Wrap (SATURATE=0): samples -2048 then 2047 give odata 0 then -1.
REQ-031 Mid-stream reset: samples 100, 200, then reset, then sample 50 give odata 0, 100, 0. ivalid asserted together with reset produces no ovalid.
REQ-032 Throughput: ivalid held high over samples 1..8 gives 8 consecutive ovalid pulses with odata 0, 1, 1, 1, 1, 1, 1, 1.
